alu_ctrl_fsm: RTL and testbench
===============================

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction bits [31:26], sampled from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 zero  input  1  ALU zero flag, valid during BRANCH.
REQ-007 pc_en  output  1  PC load enable.
REQ-008 i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 mem_read, mem_write, ir_write  output  1 each  memory read, memory write and IR load strobes.
REQ-010 reg_dst, mem_to_reg, reg_write  output  1 each  register-file write controls.
REQ-011 alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs.
REQ-012 alu_src_b  output  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-013 pc_source  output  2  PC mux select: 00 = ALU, 01 = ALU result register, 10 = jump target.
REQ-014 seletora  output  3  ALU operation select driven to the downstream ALU result mux.
REQ-015 estado  output  4  current state code, for debug.

Function
REQ-016 seletora encoding SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; no other value SHALL ever be driven.
REQ-017 States and codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
REQ-018 The state register SHALL update on the rising edge of clk; all outputs SHALL be combinational from state (Moore), with two exceptions: pc_en in BRANCH (depends on zero) and seletora/reg_write in EXEC/ALUWB (depend on funct).
REQ-019 Each state SHALL drive only the controls listed here; every unlisted output SHALL be 0:
- FETCH: mem_read, ir_write, alu_src_b=01, seletora=010, pc_source=00, pc_en=1.
- DECODE: alu_src_b=11, seletora=010.
- MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, seletora=010.
- MEMRD: mem_read, i_or_d=1.
- MEMWB: reg_write, mem_to_reg=1.
- MEMWR: mem_write, i_or_d=1.
- EXEC: alu_src_a=1, seletora from funct.
- ALUWB: reg_dst=1, reg_write.
- BRANCH: alu_src_a=1, seletora=110, pc_source=01, pc_en=zero.
- JUMP: pc_source=10, pc_en=1.
- ADDIWB: reg_write.
REQ-020 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE, by opcode: 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; any other opcode -> FETCH (treated as a NOP).
- MEMADR -> MEMRD if opcode=100011, else MEMWR.
- MEMRD -> MEMWB; EXEC -> ALUWB; ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB -> FETCH.
- Illegal state codes 12-15 -> FETCH on the next edge.
REQ-021 funct decode in EXEC and ALUWB SHALL be: 100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 101010 SLT.
REQ-022 For any other funct, seletora SHALL be 010 and reg_write SHALL be 0 in ALUWB.
REQ-023 Instruction latency in cycles, counted from FETCH entry, SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, unknown opcode 2.
REQ-024 BRANCH with zero=0 SHALL keep pc_en=0 for the whole cycle.

Reset
REQ-025 rst_n=0 SHALL force state to FETCH immediately, without waiting for a clock edge, from any state including mid-instruction.
REQ-026 While rst_n=0, outputs SHALL be the FETCH decode with pc_en, mem_read and ir_write forced to 0, and estado=0.
REQ-027 The first rising edge after rst_n deasserts SHALL execute FETCH.

Verification
REQ-028 Reset pulse asserted mid-MEMRD -> estado=0 asynchronously; the first cycle after release shows FETCH outputs with pc_en=1.
REQ-029 opcode=000000, funct=101010 -> estado sequence 0,1,6,7,0; seletora=111 in EXEC; reg_write=1 and reg_dst=1 in ALUWB.
REQ-030 opcode=100011 -> estado sequence 0,1,2,3,4,0; i_or_d=1 in MEMRD; mem_to_reg=1 in MEMWB.
REQ-031 opcode=000100: with zero=1, BRANCH gives pc_en=1 and seletora=110; with zero=0, pc_en=0; the next state is 0 in both cases.
REQ-032 opcode=111111 -> estado sequence 0,1,0, and no write strobe is asserted.
REQ-033 R-type with funct=000000 -> seletora=010 in EXEC; reg_write=0 in ALUWB.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle MIPS-style control unit: Moore state machine driving datapath
// strobes, with zero-dependent PC enable in BRANCH and funct-dependent ALU select.
module alu_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] seletora,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_funct_op;
  logic       w_funct_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Unrecognised funct falls back to ADD and suppresses the register write.
  always_comb begin
    w_funct_op = ALU_ADD;
    w_funct_ok = 1'b1;
    case (funct)
      6'b100100: w_funct_op = ALU_AND;
      6'b100101: w_funct_op = ALU_OR;
      6'b100000: w_funct_op = ALU_ADD;
      6'b100010: w_funct_op = ALU_SUB;
      6'b101010: w_funct_op = ALU_SLT;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    seletora   = ALU_AND;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        seletora  = ALU_ADD;
        pc_en     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        seletora  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        seletora  = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        seletora  = w_funct_op;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = w_funct_ok;
        seletora  = w_funct_op;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        seletora  = ALU_SUB;
        pc_source = 2'b01;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    // Held in reset: show FETCH decode but block every side-effecting strobe.
    if (!rst_n) begin
      pc_en    = 1'b0;
      mem_read = 1'b0;
      ir_write = 1'b0;
    end
  end

  assign estado = r_state;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: walks each instruction class through its
// state sequence and checks strobes against hand-derived values.
module tb_alu_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] seletora;
  logic [3:0] estado;

  int n_cmp = 0;
  int n_err = 0;

  alu_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .seletora   (seletora),
    .estado     (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_estado", estado, 4'd0);
    chk("rst_pc_en", {3'b0, pc_en}, 4'd0);
    chk("rst_mem_read", {3'b0, mem_read}, 4'd0);
    chk("rst_ir_write", {3'b0, ir_write}, 4'd0);
    chk("rst_alu_src_b", {2'b0, alu_src_b}, 4'd1);
    chk("rst_seletora", {1'b0, seletora}, 4'd2);

    // R-type SLT
    opcode = 6'b000000; funct = 6'b101010;
    rst_n = 1'b1;
    #1;
    chk("rel_fetch_estado", estado, 4'd0);
    chk("rel_fetch_pc_en", {3'b0, pc_en}, 4'd1);
    chk("rel_fetch_mem_read", {3'b0, mem_read}, 4'd1);
    chk("rel_fetch_ir_write", {3'b0, ir_write}, 4'd1);
    tick();
    chk("slt_decode", estado, 4'd1);
    chk("slt_decode_srcb", {2'b0, alu_src_b}, 4'd3);
    chk("slt_decode_sel", {1'b0, seletora}, 4'd2);
    tick();
    chk("slt_exec", estado, 4'd6);
    chk("slt_exec_sel", {1'b0, seletora}, 4'd7);
    chk("slt_exec_srca", {3'b0, alu_src_a}, 4'd1);
    tick();
    chk("slt_aluwb", estado, 4'd7);
    chk("slt_aluwb_regwrite", {3'b0, reg_write}, 4'd1);
    chk("slt_aluwb_regdst", {3'b0, reg_dst}, 4'd1);
    tick();
    chk("slt_back_fetch", estado, 4'd0);

    // lw
    opcode = 6'b100011;
    tick();
    chk("lw_decode", estado, 4'd1);
    tick();
    chk("lw_memadr", estado, 4'd2);
    chk("lw_memadr_srcb", {2'b0, alu_src_b}, 4'd2);
    tick();
    chk("lw_memrd", estado, 4'd3);
    chk("lw_memrd_iord", {3'b0, i_or_d}, 4'd1);
    chk("lw_memrd_memread", {3'b0, mem_read}, 4'd1);
    tick();
    chk("lw_memwb", estado, 4'd4);
    chk("lw_memwb_memtoreg", {3'b0, mem_to_reg}, 4'd1);
    chk("lw_memwb_regwrite", {3'b0, reg_write}, 4'd1);
    tick();
    chk("lw_back_fetch", estado, 4'd0);

    // sw
    opcode = 6'b101011;
    tick();
    tick();
    chk("sw_memadr", estado, 4'd2);
    tick();
    chk("sw_memwr", estado, 4'd5);
    chk("sw_memwr_memwrite", {3'b0, mem_write}, 4'd1);
    chk("sw_memwr_iord", {3'b0, i_or_d}, 4'd1);
    tick();
    chk("sw_back_fetch", estado, 4'd0);

    // beq taken, then zero dropped inside the same BRANCH cycle
    opcode = 6'b000100; zero = 1'b1;
    tick();
    tick();
    chk("beq1_branch", estado, 4'd8);
    chk("beq1_pc_en", {3'b0, pc_en}, 4'd1);
    chk("beq1_sel", {1'b0, seletora}, 4'd6);
    chk("beq1_pcsrc", {2'b0, pc_source}, 4'd1);
    zero = 1'b0;
    #1;
    chk("beq_zero_drop_pc_en", {3'b0, pc_en}, 4'd0);
    tick();
    chk("beq1_back_fetch", estado, 4'd0);

    // beq not taken
    zero = 1'b0;
    tick();
    tick();
    chk("beq0_branch", estado, 4'd8);
    chk("beq0_pc_en", {3'b0, pc_en}, 4'd0);
    tick();
    chk("beq0_back_fetch", estado, 4'd0);

    // j
    opcode = 6'b000010;
    tick();
    tick();
    chk("j_jump", estado, 4'd9);
    chk("j_pcsrc", {2'b0, pc_source}, 4'd2);
    chk("j_pc_en", {3'b0, pc_en}, 4'd1);
    tick();
    chk("j_back_fetch", estado, 4'd0);

    // addi
    opcode = 6'b001000;
    tick();
    tick();
    chk("addi_ex", estado, 4'd10);
    chk("addi_ex_srcb", {2'b0, alu_src_b}, 4'd2);
    tick();
    chk("addi_wb", estado, 4'd11);
    chk("addi_wb_regwrite", {3'b0, reg_write}, 4'd1);
    tick();
    chk("addi_back_fetch", estado, 4'd0);

    // unknown opcode acts as NOP
    opcode = 6'b111111;
    tick();
    chk("nop_decode", estado, 4'd1);
    chk("nop_memwrite", {3'b0, mem_write}, 4'd0);
    chk("nop_regwrite", {3'b0, reg_write}, 4'd0);
    tick();
    chk("nop_back_fetch", estado, 4'd0);

    // R-type with unsupported funct
    opcode = 6'b000000; funct = 6'b000000;
    tick();
    tick();
    chk("badf_exec", estado, 4'd6);
    chk("badf_exec_sel", {1'b0, seletora}, 4'd2);
    tick();
    chk("badf_aluwb", estado, 4'd7);
    chk("badf_aluwb_regwrite", {3'b0, reg_write}, 4'd0);
    tick();
    chk("badf_back_fetch", estado, 4'd0);

    // Reset pulse in the middle of MEMRD
    opcode = 6'b100011;
    tick();
    tick();
    tick();
    chk("rstmid_memrd", estado, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_estado", estado, 4'd0);
    chk("rstmid_async_pc_en", {3'b0, pc_en}, 4'd0);
    chk("rstmid_async_memread", {3'b0, mem_read}, 4'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstmid_rel_estado", estado, 4'd0);
    chk("rstmid_rel_pc_en", {3'b0, pc_en}, 4'd1);
    chk("rstmid_rel_irwrite", {3'b0, ir_write}, 4'd1);
    tick();
    chk("rstmid_decode", estado, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
